// File: rtl/disp_scroll_ctrl_pkg.sv
// Shared constants and types for the 4-digit scrolling display source.
// Optional feature macro: DISP_SCROLL_DIR_EN (adds scroll_dir to the interface).
package disp_pkg;

  localparam int unsigned CHAR_W           = 4;
  localparam int unsigned NUM_DIGITS       = 4;
  localparam int unsigned MSG_AW           = 4;
  localparam int unsigned PHASES_PER_DIGIT = 4;
  localparam int unsigned PHASE_W          = 4;

  typedef logic [CHAR_W-1:0] char_t;
  typedef char_t [(2**MSG_AW)-1:0] msg_t;

  // Entry i holds character i after reset.
  localparam msg_t RESET_MSG = 64'hFEDC_BA98_7654_3210;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } scroll_dir_e;

endpackage

// File: rtl/disp_scroll_ctrl_if.sv
// Message-write, scroll-control and display-output bundle of disp_scroll_ctrl.
// Optional feature macro: DISP_SCROLL_DIR_EN (adds scroll_dir).
interface disp_scroll_ctrl_if;
  import disp_pkg::*;

  logic                 msg_wr_en;
  logic [MSG_AW-1:0]    msg_wr_addr;
  char_t                msg_wr_data;
  logic                 scroll_en;
  logic                 step_req;
`ifdef DISP_SCROLL_DIR_EN
  logic                 scroll_dir;
`endif
  logic [PHASE_W-1:0]   count;
  char_t                char_A3;
  char_t                char_A2;
  char_t                char_A1;
  char_t                char_A0;
  logic                 frame_tick;
  logic [MSG_AW-1:0]    head_ptr;

  modport master (
    output msg_wr_en, msg_wr_addr, msg_wr_data, scroll_en, step_req,
`ifdef DISP_SCROLL_DIR_EN
    output scroll_dir,
`endif
    input  count, char_A3, char_A2, char_A1, char_A0, frame_tick, head_ptr
  );

  modport slave (
    input  msg_wr_en, msg_wr_addr, msg_wr_data, scroll_en, step_req,
`ifdef DISP_SCROLL_DIR_EN
    input  scroll_dir,
`endif
    output count, char_A3, char_A2, char_A1, char_A0, frame_tick, head_ptr
  );

endinterface

// File: rtl/disp_scroll_ctrl_refresh_timer.sv
// Refresh phase generator: prescaler, 16-phase count and end-of-frame pulse.
module disp_refresh_timer
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 2500
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PHASE_W-1:0] count,
  output logic               frame_tick
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler;
  logic          phase_end;

  assign phase_end = (prescaler == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= '0;
      count      <= '0;
      frame_tick <= 1'b0;
    end else begin
      // Registered so the pulse lines up with the cycle count reads 0 again.
      frame_tick <= phase_end && (count == '1);
      if (phase_end) begin
        prescaler <= '0;
        count     <= count + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_scroll_ctrl.sv
// Scrolling message source for the 4-digit multiplexed display.
// Optional feature macro: DISP_SCROLL_DIR_EN (scroll_dir selects +1/-1 head steps).
module disp_scroll_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = 2500,
  parameter int unsigned SCROLL_FRAMES = 1500,
  parameter int unsigned MSG_LEN       = 16
) (
  input logic               clk,
  input logic               reset,
  disp_scroll_ctrl_if.slave bus
);

  localparam int unsigned FCW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(SCROLL_FRAMES - 1);

  logic [PHASE_W-1:0] count;
  logic               frame_tick;
  char_t              message [MSG_LEN];
  logic [FCW-1:0]     frame_cnt;
  logic [MSG_AW-1:0]  head_ptr;
  logic [MSG_AW-1:0]  head_next;
  logic [MSG_AW-1:0]  head_step;
  logic               step_pending;
  logic               advance;
  char_t              snap   [NUM_DIGITS];
  char_t              disp_q [NUM_DIGITS];

  disp_refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_refresh_timer (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .frame_tick (frame_tick)
  );

  always_comb begin
    head_step = MSG_AW'(1);
`ifdef DISP_SCROLL_DIR_EN
    if (scroll_dir_e'(bus.scroll_dir) == DIR_REV) head_step = '1;
`endif
    advance   = frame_tick && (bus.scroll_en ? (frame_cnt == FC_LAST) : step_pending);
    head_next = advance ? (head_ptr + head_step) : head_ptr;
    // Snapshot reads the pre-write array, so a same-cycle write shows next frame.
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      snap[k] = message[head_next + MSG_AW'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < MSG_LEN; i++) begin
        message[MSG_AW'(i)] <= RESET_MSG[MSG_AW'(i)];
      end
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        disp_q[k] <= RESET_MSG[MSG_AW'(k)];
      end
      frame_cnt    <= '0;
      head_ptr     <= '0;
      step_pending <= 1'b0;
    end else begin
      if (bus.msg_wr_en) message[bus.msg_wr_addr] <= bus.msg_wr_data;

      if (frame_tick && bus.scroll_en) begin
        frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
      end

      // A request arriving on the advance tick itself queues the next step.
      if (bus.step_req && !bus.scroll_en) begin
        step_pending <= 1'b1;
      end else if (advance) begin
        step_pending <= 1'b0;
      end

      head_ptr <= head_next;

      if (frame_tick) begin
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
          disp_q[k] <= snap[k];
        end
      end
    end
  end

  assign bus.count      = count;
  assign bus.frame_tick = frame_tick;
  assign bus.head_ptr   = head_ptr;
  assign bus.char_A3    = disp_q[0];
  assign bus.char_A2    = disp_q[1];
  assign bus.char_A1    = disp_q[2];
  assign bus.char_A0    = disp_q[3];

endmodule

// File: tb/tb_disp_scroll_ctrl.sv
// Self-checking bench for disp_scroll_ctrl with REFRESH_DIV=2, SCROLL_FRAMES=2.
module tb_disp_scroll_ctrl;
  import disp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  disp_scroll_ctrl_if bus();

  disp_scroll_ctrl #(
    .REFRESH_DIV   (2),
    .SCROLL_FRAMES (2),
    .MSG_LEN       (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  head;
    logic [15:0] chars;
  } exp_t;

  typedef struct {
    logic        sen;
    int          steps;
    logic        we;
    logic [3:0]  wa;
    logic [3:0]  wd;
    logic [3:0]  eh;
    logic [15:0] ec;
  } vec_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  bm [16];
  logic [15:0] shown;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dut_chars();
    return {bus.char_A3, bus.char_A2, bus.char_A1, bus.char_A0};
  endfunction

  function automatic logic [15:0] model_chars(input logic [3:0] h);
    logic [3:0] h1, h2, h3;
    h1 = h + 4'd1;
    h2 = h + 4'd2;
    h3 = h + 4'd3;
    return {bm[h], bm[h1], bm[h2], bm[h3]};
  endfunction

  function automatic vec_t mk(input logic sen, input int steps, input logic we,
                              input logic [3:0] wa, input logic [3:0] wd,
                              input logic [3:0] eh, input logic [15:0] ec);
    vec_t v;
    v.sen = sen; v.steps = steps; v.we = we; v.wa = wa; v.wd = wd; v.eh = eh; v.ec = ec;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) bm[i] = 4'(i);
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_tick_timeout: actual=no pulse in 40 cycles required=pulse");
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: actual=empty required=entry", name);
      return;
    end
    e = sb_q.pop_front();
    chk({name, "_head"}, 32'(bus.head_ptr), 32'(e.head));
    chk({name, "_chars"}, 32'(dut_chars()), 32'(e.chars));
    shown = e.chars;
  endtask

  // Entered just after a snapshot edge; drives one frame of stimulus.
  task automatic run_frame(input vec_t v, input string name);
    exp_t e;
    e.head  = v.eh;
    e.chars = v.ec;
    sb_q.push_back(e);
    bus.scroll_en = v.sen;
    for (int s = 0; s < v.steps; s++) begin
      bus.step_req = 1'b1;
      @(negedge clk);
      bus.step_req = 1'b0;
      @(negedge clk);
    end
    if (v.we) begin
      bus.msg_wr_en   = 1'b1;
      bus.msg_wr_addr = v.wa;
      bus.msg_wr_data = v.wd;
      @(negedge clk);
      bus.msg_wr_en = 1'b0;
      bm[v.wa]      = v.wd;
    end
    chk({name, "_stable"}, 32'(dut_chars()), 32'(shown));
    wait_tick();
    @(negedge clk);
    pop_check(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       tbl [7];
    logic [3:0] h;
    int         fc;
    exp_t       e;

    tbl = '{
      mk(1'b0, 0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0123),
      mk(1'b0, 0, 1'b1, 4'h2, 4'hA, 4'h0, 16'h01A3),
      mk(1'b0, 0, 1'b1, 4'h2, 4'h2, 4'h0, 16'h0123),
      mk(1'b1, 0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0123),
      mk(1'b1, 0, 1'b0, 4'h0, 4'h0, 4'h1, 16'h1234),
      mk(1'b0, 3, 1'b0, 4'h0, 4'h0, 4'h2, 16'h2345),
      mk(1'b0, 0, 1'b0, 4'h0, 4'h0, 4'h2, 16'h2345)
    };

    bus.msg_wr_en   = 1'b0;
    bus.msg_wr_addr = '0;
    bus.msg_wr_data = '0;
    bus.scroll_en   = 1'b0;
    bus.step_req    = 1'b0;
`ifdef DISP_SCROLL_DIR_EN
    bus.scroll_dir  = 1'b0;
`endif
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);

    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_frame_tick", 32'(bus.frame_tick), 32'd0);
    chk("rst_head", 32'(bus.head_ptr), 32'd0);
    chk("rst_chars", 32'(dut_chars()), 32'h0123);

    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk($sformatf("count_k%0d", k), 32'(bus.count), 32'((k / 2) % 16));
      chk($sformatf("tick_k%0d", k), 32'(bus.frame_tick), 32'(k == 32));
    end
    @(negedge clk);
    chk("first_frame_chars", 32'(dut_chars()), 32'h0123);
    shown = 16'h0123;

    for (int i = 0; i < 7; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    // Auto-scroll through the wrap back to head 0.
    h  = 4'h2;
    fc = 0;
    for (int f = 0; f < 28; f++) begin
      if (fc == 1) begin
        h  = h + 4'd1;
        fc = 0;
      end else begin
        fc = 1;
      end
      run_frame(mk(1'b1, 0, 1'b0, 4'h0, 4'h0, h, model_chars(h)), $sformatf("scroll%0d", f));
    end
    chk("scroll_wrapped_head", 32'(bus.head_ptr), 32'd0);

    // Write landing on the snapshot edge: old data this frame, new next frame.
    bus.scroll_en = 1'b0;
    e.head  = 4'h0;
    e.chars = model_chars(4'h0);
    sb_q.push_back(e);
    wait_tick();
    bus.msg_wr_en   = 1'b1;
    bus.msg_wr_addr = 4'h3;
    bus.msg_wr_data = 4'h9;
    @(negedge clk);
    bus.msg_wr_en = 1'b0;
    pop_check("coincide_old");
    bm[3] = 4'h9;
    run_frame(mk(1'b0, 0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0129), "coincide_new");

    h = 4'h0;
    for (int s = 0; s < 7; s++) begin
      h = h + 4'd1;
      run_frame(mk(1'b0, 1, 1'b0, 4'h0, 4'h0, h, model_chars(h)), $sformatf("step%0d", s));
    end

    // Mid-frame reset with head_ptr=7.
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_tick", 32'(bus.frame_tick), 32'd0);
    chk("midrst_head", 32'(bus.head_ptr), 32'd0);
    chk("midrst_chars", 32'(dut_chars()), 32'h0123);
    reset = 1'b0;
    model_reset();
    shown = 16'h0123;
    @(negedge clk);
    chk("midrst_count_a", 32'(bus.count), 32'd0);
    @(negedge clk);
    chk("midrst_count_b", 32'(bus.count), 32'd1);
    run_frame(mk(1'b0, 0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0123), "after_rst");

`ifdef DISP_SCROLL_DIR_EN
    bus.scroll_dir = 1'b1;
    run_frame(mk(1'b0, 1, 1'b0, 4'h0, 4'h0, 4'hF, 16'hF012), "dir_rev");
    bus.scroll_dir = 1'b0;
`endif

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
